ray_scheduler: RTL and testbench

//   Frame-level controller for a bank of NUM_UNITS ray_unit instances.
//   - Walks every pixel of the frame in raster order.
//   - Dispatches each pixel to a free unit over that unit's valid/ready handshake.
//   - Detects completion of each unit and collects its result.
//   - Serialises results into framebuffer writes, at most one per cycle.

---
 rtl/ray_scheduler_if.sv | 35 +++
 rtl/ray_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_ray_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ray_scheduler_if.sv
// Bundles the ray-unit dispatch/result signals and the framebuffer write
// port of ray_scheduler. The scheduler uses the master modport; the ray
// units and the framebuffer sit on the slave side.
interface ray_scheduler_if #(
    parameter int NUM_UNITS = 4,
    parameter int H_BITS    = 3,
    parameter int V_BITS    = 2,
    parameter int ADDR_BITS = 5
);
    logic [NUM_UNITS-1:0]        unit_valid_out;
    logic [H_BITS-1:0]           unit_hcount_out;
    logic [V_BITS-1:0]           unit_vcount_out;
    logic [NUM_UNITS-1:0]        unit_ready_in;
    logic [NUM_UNITS*H_BITS-1:0] unit_hcount_in;
    logic [NUM_UNITS*V_BITS-1:0] unit_vcount_in;
    logic [NUM_UNITS*4-1:0]      unit_color_in;
    logic                        fb_we_out;
    logic [ADDR_BITS-1:0]        fb_addr_out;
    logic [3:0]                  fb_data_out;
    logic                        fb_ready_in;

    modport master (
        output unit_valid_out, unit_hcount_out, unit_vcount_out,
        output fb_we_out, fb_addr_out, fb_data_out,
        input  unit_ready_in, unit_hcount_in, unit_vcount_in, unit_color_in,
        input  fb_ready_in
    );

    modport slave (
        input  unit_valid_out, unit_hcount_out, unit_vcount_out,
        input  fb_we_out, fb_addr_out, fb_data_out,
        output unit_ready_in, unit_hcount_in, unit_vcount_in, unit_color_in,
        output fb_ready_in
    );
endinterface

// File: rtl/ray_scheduler.sv
// Frame-level controller for a bank of ray units: walks the frame in raster
// order, dispatches pixels round-robin to free units, tracks each unit in a
// small slot FSM and serialises finished results into framebuffer writes.
module ray_scheduler #(
    parameter int NUM_UNITS      = 4,
    parameter int DISPLAY_WIDTH  = 8,
    parameter int DISPLAY_HEIGHT = 4,
    parameter int H_BITS         = 3,
    parameter int V_BITS         = 2,
    parameter int ADDR_BITS      = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           start_in,
    output logic           busy_out,
    output logic           frame_done_out,
    ray_scheduler_if.master bus
);
    localparam int PTR_BITS = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {SL_IDLE, SL_WAIT, SL_BUSY, SL_PENDING} slot_t;

    state_t                r_state;
    state_t                w_state_nxt;
    slot_t                 r_slot [NUM_UNITS];
    logic [H_BITS-1:0]     r_hcount;
    logic [V_BITS-1:0]     r_vcount;
    logic [PTR_BITS-1:0]   r_disp_ptr;
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic                  r_wr_lock;
    logic [PTR_BITS-1:0]   r_wr_sel;

    logic                  w_disp_found;
    logic                  w_disp_go;
    logic [PTR_BITS-1:0]   w_disp_sel;
    logic [PTR_BITS-1:0]   w_didx;
    logic                  w_wr_found;
    logic                  w_wr_active;
    logic                  w_wr_done;
    logic [PTR_BITS-1:0]   w_wr_sel;
    logic [PTR_BITS-1:0]   w_widx;
    logic                  w_last_pix;
    logic                  w_all_idle_next;
    logic [NUM_UNITS-1:0]  w_valid;
    logic [H_BITS-1:0]     w_res_h;
    logic [V_BITS-1:0]     w_res_v;
    logic [ADDR_BITS-1:0]  w_addr;
    logic [3:0]            w_data;

    // Round-robin pointer advance, wrapping at the last unit.
    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        if (int'(p) == NUM_UNITS - 1) begin
            return '0;
        end else begin
            return p + PTR_BITS'(1);
        end
    endfunction

    assign w_last_pix = (r_hcount == H_BITS'(DISPLAY_WIDTH - 1)) &&
                        (r_vcount == V_BITS'(DISPLAY_HEIGHT - 1));

    // Dispatch arbiter: first IDLE and ready unit at or after the dispatch pointer.
    always_comb begin
        w_disp_found = 1'b0;
        w_disp_sel   = '0;
        w_didx       = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_didx = PTR_BITS'((int'(r_disp_ptr) + i) % NUM_UNITS);
            if (!w_disp_found && (r_slot[w_didx] == SL_IDLE) && bus.unit_ready_in[w_didx]) begin
                w_disp_found = 1'b1;
                w_disp_sel   = w_didx;
            end else begin
                w_disp_found = w_disp_found;
            end
        end
        w_disp_go = (r_state == S_RUN) && w_disp_found;
    end

    // Write-back arbiter: a stalled write keeps its unit until the framebuffer accepts it.
    always_comb begin
        w_wr_found = 1'b0;
        w_wr_sel   = '0;
        w_widx     = '0;
        if (r_wr_lock) begin
            w_wr_found = 1'b1;
            w_wr_sel   = r_wr_sel;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                w_widx = PTR_BITS'((int'(r_wr_ptr) + i) % NUM_UNITS);
                if (!w_wr_found && (r_slot[w_widx] == SL_PENDING)) begin
                    w_wr_found = 1'b1;
                    w_wr_sel   = w_widx;
                end else begin
                    w_wr_found = w_wr_found;
                end
            end
        end
        w_wr_active = ((r_state == S_RUN) || (r_state == S_DRAIN)) && w_wr_found;
        w_wr_done   = w_wr_active && bus.fb_ready_in;
    end

    // Dispatch strobe and framebuffer write fields from the selected units.
    always_comb begin
        w_valid = '0;
        if (w_disp_go) begin
            w_valid[w_disp_sel] = 1'b1;
        end else begin
            w_valid = '0;
        end
        w_res_h = bus.unit_hcount_in[int'(w_wr_sel)*H_BITS +: H_BITS];
        w_res_v = bus.unit_vcount_in[int'(w_wr_sel)*V_BITS +: V_BITS];
        if (w_wr_active) begin
            w_addr = ADDR_BITS'(w_res_v) * ADDR_BITS'(DISPLAY_WIDTH) + ADDR_BITS'(w_res_h);
            w_data = bus.unit_color_in[int'(w_wr_sel)*4 +: 4];
        end else begin
            w_addr = '0;
            w_data = '0;
        end
    end

    assign bus.unit_valid_out  = w_valid;
    assign bus.unit_hcount_out = r_hcount;
    assign bus.unit_vcount_out = r_vcount;
    assign bus.fb_we_out       = w_wr_active;
    assign bus.fb_addr_out     = w_addr;
    assign bus.fb_data_out     = w_data;
    assign busy_out            = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign frame_done_out      = (r_state == S_DONE);

    // Top FSM next state; drain ends in the cycle the final write completes.
    always_comb begin
        w_all_idle_next = 1'b1;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!((r_slot[i] == SL_IDLE) ||
                  ((r_slot[i] == SL_PENDING) && w_wr_done && (w_wr_sel == PTR_BITS'(i))))) begin
                w_all_idle_next = 1'b0;
            end else begin
                w_all_idle_next = w_all_idle_next;
            end
        end
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start_in ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = (w_disp_go && w_last_pix) ? S_DRAIN : S_RUN;
            S_DRAIN: w_state_nxt = w_all_idle_next ? S_DONE : S_DRAIN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Top FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Raster pixel counters: cleared on frame start and after the last pixel.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if ((r_state == S_IDLE) && start_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_disp_go) begin
            if (w_last_pix) begin
                r_hcount <= '0;
                r_vcount <= '0;
            end else if (r_hcount == H_BITS'(DISPLAY_WIDTH - 1)) begin
                r_hcount <= '0;
                r_vcount <= r_vcount + V_BITS'(1);
            end else begin
                r_hcount <= r_hcount + H_BITS'(1);
            end
        end
    end

    // Per-unit slot FSMs; WAIT masks the unit's stale ready for one cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_slot[i] <= SL_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                case (r_slot[i])
                    SL_IDLE:    if (w_disp_go && (w_disp_sel == PTR_BITS'(i))) r_slot[i] <= SL_WAIT;
                    SL_WAIT:    r_slot[i] <= SL_BUSY;
                    SL_BUSY:    if (bus.unit_ready_in[i]) r_slot[i] <= SL_PENDING;
                    SL_PENDING: if (w_wr_done && (w_wr_sel == PTR_BITS'(i))) r_slot[i] <= SL_IDLE;
                    default:    r_slot[i] <= SL_IDLE;
                endcase
            end
        end
    end

    // Round-robin pointers and the stalled-write lock.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_disp_ptr <= '0;
            r_wr_ptr   <= '0;
            r_wr_lock  <= 1'b0;
            r_wr_sel   <= '0;
        end else begin
            if (w_disp_go) begin
                r_disp_ptr <= ptr_inc(w_disp_sel);
            end
            if (w_wr_done) begin
                r_wr_ptr  <= ptr_inc(w_wr_sel);
                r_wr_lock <= 1'b0;
            end else if (w_wr_active) begin
                r_wr_lock <= 1'b1;
                r_wr_sel  <= w_wr_sel;
            end else begin
                r_wr_lock <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ray_scheduler.sv
// Bench for ray_scheduler: 4x2 frame, two modelled ray units, scoreboard of
// expected framebuffer writes filled at frame start and drained by a monitor.
module tb_ray_scheduler;
    localparam int NU  = 2;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int HB  = 2;
    localparam int VB  = 1;
    localparam int AB  = 3;
    localparam int PIX = W * H;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic start_in = 1'b0;
    logic busy_out;
    logic frame_done_out;

    ray_scheduler_if #(.NUM_UNITS(NU), .H_BITS(HB), .V_BITS(VB), .ADDR_BITS(AB)) bus ();

    ray_scheduler #(
        .NUM_UNITS(NU), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
        .H_BITS(HB), .V_BITS(VB), .ADDR_BITS(AB)
    ) u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .busy_out(busy_out), .frame_done_out(frame_done_out), .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference colour of a pixel, by framebuffer address.
    function automatic logic [3:0] px_color(input int a);
        int t;
        t = (a * 7 + 3) ^ (a >> 1);
        return t[3:0];
    endfunction

    // ---------------- ray unit models ----------------
    logic [NU-1:0]         u_rdy;
    logic [NU-1:0][HB-1:0] u_h;
    logic [NU-1:0][VB-1:0] u_v;
    logic [NU-1:0][3:0]    u_c;
    int                    u_cnt [NU];
    int                    lat_fix [NU];
    bit                    lat_rand = 1'b0;

    assign bus.unit_ready_in  = u_rdy;
    assign bus.unit_hcount_in = u_h;
    assign bus.unit_vcount_in = u_v;
    assign bus.unit_color_in  = u_c;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            u_rdy <= '1;
            u_h   <= '0;
            u_v   <= '0;
            u_c   <= '0;
            for (int u = 0; u < NU; u++) u_cnt[u] <= 0;
        end else begin
            for (int u = 0; u < NU; u++) begin
                if (bus.unit_valid_out[u]) begin
                    u_rdy[u] <= 1'b0;
                    u_cnt[u] <= lat_rand ? int'($urandom_range(1, 6)) : lat_fix[u];
                    u_h[u]   <= bus.unit_hcount_out;
                    u_v[u]   <= bus.unit_vcount_out;
                    u_c[u]   <= px_color(int'(bus.unit_vcount_out) * W + int'(bus.unit_hcount_out));
                end else if (!u_rdy[u]) begin
                    if (u_cnt[u] <= 1) u_rdy[u] <= 1'b1;
                    else               u_cnt[u] <= u_cnt[u] - 1;
                end
            end
        end
    end

    // ---------------- framebuffer ready driver ----------------
    logic fb_ready = 1'b1;
    bit   fb_rand  = 1'b0;
    logic fb_force = 1'b1;
    assign bus.fb_ready_in = fb_ready;

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            fb_ready = fb_rand ? logic'($urandom_range(0, 3) != 0) : fb_force;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int exp_q[$];
    int wr_log[$];
    bit outst [NU];
    int pix_of [NU];
    int disp_idx     = PIX;
    int frame_writes = 0;
    int disp_u0      = 0;
    int last_wr_cyc  = -10;
    int last_wr_unit = -1;
    int done_count   = 0;
    int m_u, m_a, m_qi;

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (bus.unit_valid_out != '0) begin
                m_u = 0;
                for (int k = 0; k < NU; k++) if (bus.unit_valid_out[k]) m_u = k;
                check($onehot(bus.unit_valid_out), "disp_onehot", int'(bus.unit_valid_out), 1 << m_u);
                check(disp_idx < PIX, "disp_beyond_frame", disp_idx, PIX - 1);
                check(int'(bus.unit_hcount_out) == disp_idx % W, "disp_hcount", int'(bus.unit_hcount_out), disp_idx % W);
                check(int'(bus.unit_vcount_out) == disp_idx / W, "disp_vcount", int'(bus.unit_vcount_out), disp_idx / W);
                check(!outst[m_u], "disp_to_pending_unit", int'(outst[m_u]), 0);
                check(u_rdy[m_u] == 1'b1, "disp_to_unready_unit", int'(u_rdy[m_u]), 1);
                check(busy_out == 1'b1, "busy_during_dispatch", int'(busy_out), 1);
                outst[m_u]  = 1'b1;
                pix_of[m_u] = disp_idx;
                disp_idx++;
                if (m_u == 0) disp_u0++;
            end
            if (bus.fb_we_out && fb_ready) begin
                m_a  = int'(bus.fb_addr_out);
                m_u  = -1;
                m_qi = -1;
                for (int k = 0; k < NU; k++) if (outst[k] && pix_of[k] == m_a) m_u = k;
                for (int i = 0; i < exp_q.size(); i++) if (exp_q[i] == m_a) m_qi = i;
                check(m_u >= 0, "wr_addr_not_in_flight", m_a, -1);
                check(m_qi >= 0, "wr_addr_not_expected", m_a, -1);
                check(bus.fb_data_out == px_color(m_a), "wr_data", int'(bus.fb_data_out), int'(px_color(m_a)));
                if (m_qi >= 0) exp_q.delete(m_qi);
                if (m_u >= 0) outst[m_u] = 1'b0;
                last_wr_cyc  = cyc;
                last_wr_unit = m_u;
                frame_writes++;
                wr_log.push_back(m_a);
            end
            if (frame_done_out) begin
                check(exp_q.size() == 0, "done_writes_left", exp_q.size(), 0);
                check(frame_writes == PIX, "done_write_count", frame_writes, PIX);
                check(disp_idx == PIX, "done_dispatch_count", disp_idx, PIX);
                check(last_wr_cyc == cyc - 1, "done_after_last_write", cyc - last_wr_cyc, 1);
                check(busy_out == 1'b0, "busy_low_at_done", int'(busy_out), 0);
                done_count++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_frame();
        @(posedge clk_in);
        #1;
        exp_q.delete();
        wr_log.delete();
        for (int a = 0; a < PIX; a++) exp_q.push_back(a);
        disp_idx     = 0;
        frame_writes = 0;
        disp_u0      = 0;
        start_in     = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int n, input string nm);
        int k;
        k = 0;
        while (done_count < n && k < 3000) begin
            @(posedge clk_in);
            k++;
        end
        check(done_count >= n, nm, done_count, n);
    endtask

    task automatic wait_dispatched(input int n);
        int k;
        k = 0;
        while (disp_idx < n && k < 500) begin
            @(posedge clk_in);
            k++;
        end
        check(disp_idx >= n, "dispatch_progress", disp_idx, n);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(busy_out == 1'b0,             {tag, "_busy"},  int'(busy_out), 0);
        check(frame_done_out == 1'b0,       {tag, "_done"},  int'(frame_done_out), 0);
        check(bus.unit_valid_out == '0,     {tag, "_valid"}, int'(bus.unit_valid_out), 0);
        check(bus.fb_we_out == 1'b0,        {tag, "_we"},    int'(bus.fb_we_out), 0);
        check(bus.fb_addr_out == '0,        {tag, "_addr"},  int'(bus.fb_addr_out), 0);
        check(bus.fb_data_out == '0,        {tag, "_data"},  int'(bus.fb_data_out), 0);
        check(bus.unit_hcount_out == '0,    {tag, "_hcnt"},  int'(bus.unit_hcount_out), 0);
        check(bus.unit_vcount_out == '0,    {tag, "_vcnt"},  int'(bus.unit_vcount_out), 0);
    endtask

    int held_a, held_d, other_a, k;

    initial begin
        lat_fix[0] = 3;
        lat_fix[1] = 3;
        for (int u = 0; u < NU; u++) outst[u] = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk_in);
        #1;
        check_outputs_zero("reset");
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;

        // Basic frame: fixed latency 3, framebuffer always ready.
        start_frame();
        wait_done(1, "frame_basic_done");
        repeat (5) @(posedge clk_in);
        check(done_count == 1, "frame_done_once", done_count, 1);

        // Unit 0 stalls for 50 cycles; unit 1 finishes in 2.
        lat_fix[0] = 50;
        lat_fix[1] = 2;
        start_frame();
        wait_done(2, "frame_stall_done");
        check(disp_u0 == 1, "stall_unit0_dispatches", disp_u0, 1);
        check(last_wr_unit == 0, "stall_unit0_last_write", last_wr_unit, 0);

        // Framebuffer stalls while both units hold results.
        lat_fix[0] = 3;
        lat_fix[1] = 3;
        fb_force   = 1'b0;
        start_frame();
        k = 0;
        while (!(outst[0] && outst[1] && u_rdy == 2'b11) && k < 200) begin
            @(posedge clk_in);
            k++;
        end
        check(k < 200, "fb_stall_both_pending", k, 0);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        held_a  = int'(bus.fb_addr_out);
        held_d  = int'(bus.fb_data_out);
        other_a = (held_a == pix_of[0]) ? pix_of[1] : pix_of[0];
        check(held_a == pix_of[0] || held_a == pix_of[1], "fb_stall_held_addr", held_a, pix_of[0]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            check(bus.fb_we_out == 1'b1,            "fb_stall_we",     int'(bus.fb_we_out), 1);
            check(int'(bus.fb_addr_out) == held_a,  "fb_stall_addr",   int'(bus.fb_addr_out), held_a);
            check(int'(bus.fb_data_out) == held_d,  "fb_stall_data",   int'(bus.fb_data_out), held_d);
            check(bus.unit_valid_out == '0,         "fb_stall_no_disp", int'(bus.unit_valid_out), 0);
        end
        fb_force = 1'b1;
        wait_done(3, "frame_fbstall_done");
        check(wr_log.size() >= 2, "fb_stall_log_size", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            check(wr_log[0] == held_a,  "fb_stall_first_write",  wr_log[0], held_a);
            check(wr_log[1] == other_a, "fb_stall_second_write", wr_log[1], other_a);
        end

        // Second start pulse in the middle of a frame is ignored.
        lat_rand = 1'b1;
        start_frame();
        wait_dispatched(3);
        @(posedge clk_in);
        #1;
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        wait_done(4, "frame_midstart_done");
        repeat (5) @(posedge clk_in);
        check(done_count == 4, "midstart_no_extra_frame", done_count, 4);
        check(busy_out == 1'b0, "midstart_idle_after", int'(busy_out), 0);

        // Asynchronous reset mid-frame, then a full frame from (0,0).
        fb_rand = 1'b1;
        start_frame();
        wait_dispatched(3);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        for (int u = 0; u < NU; u++) outst[u] = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;
        start_frame();
        wait_done(5, "frame_after_reset_done");

        // Random latencies and random framebuffer back-pressure.
        for (int n = 0; n < 6; n++) begin
            start_frame();
            wait_done(6 + n, "frame_random_done");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
